// File: rtl/serial_load_if.sv
// ============================================================================
// Module   : serial_load_if
// Purpose  : Bit-strobe input, instruction-memory write port and load status
//            bundle for serial_load_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_load_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32
);
    logic                  start;
    logic                  bit_valid;
    logic                  bit_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   word_count;

    modport master (
        output start, bit_valid, bit_data,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, word_count
    );

    modport slave (
        input  start, bit_valid, bit_data,
        output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error, word_count
    );
endinterface

`default_nettype wire

// File: rtl/serial_load_controller.sv
// ============================================================================
// Module   : serial_load_controller
// Purpose  : Assembles LSB-first serial words (header, payload) and writes the
//            payload to instruction memory from address 0 while holding the CPU.
//            Optional trailer checksum check enabled by macro LOAD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_load_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32,
    parameter int MAX_WORDS  = 4096
) (
    input  wire logic    clk,
    input  wire logic    reset,
    serial_load_if.slave bus
);

    localparam int CNT_W = $clog2(WORD_WIDTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_HEADER = 3'd1;
    localparam logic [2:0] c_LOAD   = 3'd2;
    localparam logic [2:0] c_CHECK  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd5;

    localparam logic [CNT_W-1:0]      c_LAST_BIT  = CNT_W'(WORD_WIDTH - 1);
    localparam logic [WORD_WIDTH-1:0] c_MAX_WORDS = WORD_WIDTH'(MAX_WORDS);

    logic [2:0]            r_state_q,  w_state_d;
    logic [CNT_W-1:0]      r_cnt_q,    w_cnt_d;
    logic [WORD_WIDTH-2:0] r_shift_q,  w_shift_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,   w_addr_d;
    logic [ADDR_WIDTH:0]   r_rem_q,    w_rem_d;
    logic [ADDR_WIDTH:0]   r_wc_q,     w_wc_d;
    logic                  r_we_q,     w_we_d;
    logic [ADDR_WIDTH-1:0] r_waddr_q,  w_waddr_d;
    logic [WORD_WIDTH-1:0] r_wdata_q,  w_wdata_d;
`ifdef LOAD_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_csum_q,   w_csum_d;
`endif

    logic                  w_active;
    logic                  w_word_done;
    logic [WORD_WIDTH-1:0] w_word;

    assign w_active    = (r_state_q == c_HEADER) || (r_state_q == c_LOAD) ||
                         (r_state_q == c_CHECK);
    // Only the upper W-1 bits of the shifter are kept: the oldest bit falls out
    // on the very strobe that completes a word, so w_word is the full word.
    assign w_word      = {bus.bit_data, r_shift_q};
    assign w_word_done = w_active && bus.bit_valid && (r_cnt_q == c_LAST_BIT);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_shift_d = r_shift_q;
        w_addr_d  = r_addr_q;
        w_rem_d   = r_rem_q;
        w_wc_d    = r_wc_q;
        w_we_d    = 1'b0;
        w_waddr_d = r_waddr_q;
        w_wdata_d = r_wdata_q;
`ifdef LOAD_CHECKSUM_EN
        w_csum_d  = r_csum_q;
`endif

        if (w_active && bus.bit_valid) begin
            w_shift_d = w_word[WORD_WIDTH-1:1];
            w_cnt_d   = w_word_done ? '0 : r_cnt_q + 1'b1;
        end

        case (r_state_q)
            c_IDLE, c_DONE, c_ERROR: begin
                if (bus.start) begin
                    w_state_d = c_HEADER;
                    w_cnt_d   = '0;
                    w_shift_d = '0;
                    w_addr_d  = '0;
                    w_rem_d   = '0;
                    w_wc_d    = '0;
`ifdef LOAD_CHECKSUM_EN
                    w_csum_d  = '0;
`endif
                end
            end
            c_HEADER: begin
                if (w_word_done) begin
                    if (w_word == '0) begin
                        w_state_d = c_DONE;
                    end else if (w_word > c_MAX_WORDS) begin
                        w_state_d = c_ERROR;
                    end else begin
                        w_rem_d   = w_word[ADDR_WIDTH:0];
                        w_state_d = c_LOAD;
                    end
                end
            end
            c_LOAD: begin
                // Bookkeeping advances with the write strobe so status and
                // word_count are already final during the last write cycle.
                if (w_word_done) begin
                    w_we_d    = 1'b1;
                    w_waddr_d = r_addr_q;
                    w_wdata_d = w_word;
                    w_addr_d  = r_addr_q + 1'b1;
                    w_wc_d    = r_wc_q + 1'b1;
                    w_rem_d   = r_rem_q - 1'b1;
`ifdef LOAD_CHECKSUM_EN
                    w_csum_d  = r_csum_q ^ w_word;
                    if (r_rem_q == 1) w_state_d = c_CHECK;
`else
                    if (r_rem_q == 1) w_state_d = c_DONE;
`endif
                end
            end
`ifdef LOAD_CHECKSUM_EN
            c_CHECK: begin
                if (w_word_done) begin
                    w_state_d = (w_word == r_csum_q) ? c_DONE : c_ERROR;
                end
            end
`endif
            default: w_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= c_IDLE;
            r_cnt_q   <= '0;
            r_shift_q <= '0;
            r_addr_q  <= '0;
            r_rem_q   <= '0;
            r_wc_q    <= '0;
            r_we_q    <= 1'b0;
            r_waddr_q <= '0;
            r_wdata_q <= '0;
`ifdef LOAD_CHECKSUM_EN
            r_csum_q  <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_shift_q <= w_shift_d;
            r_addr_q  <= w_addr_d;
            r_rem_q   <= w_rem_d;
            r_wc_q    <= w_wc_d;
            r_we_q    <= w_we_d;
            r_waddr_q <= w_waddr_d;
            r_wdata_q <= w_wdata_d;
`ifdef LOAD_CHECKSUM_EN
            r_csum_q  <= w_csum_d;
`endif
        end
    end

    assign bus.mem_we     = r_we_q;
    assign bus.mem_addr   = r_waddr_q;
    assign bus.mem_wdata  = r_wdata_q;
    assign bus.busy       = w_active;
    assign bus.cpu_hold   = w_active || (r_state_q == c_ERROR);
    assign bus.done       = (r_state_q == c_DONE);
    assign bus.error      = (r_state_q == c_ERROR);
    assign bus.word_count = r_wc_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_load_controller.sv
// ============================================================================
// Module   : tb_serial_load_controller
// Purpose  : Scoreboard bench: stimulus queues expected memory writes, a
//            negedge monitor pops and compares them; status checked per load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_load_controller;

    localparam int AW  = 12;
    localparam int W   = 32;
    localparam int MAX = 4096;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        int            t;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_load_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(W)) bus ();

    serial_load_controller #(.ADDR_WIDTH(AW), .WORD_WIDTH(W), .MAX_WORDS(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   neg_cnt  = 0;
    wr_t  sb[$];
    wr_t  mon_e;
    int   gap_max  = 0;
    bit   poke_start = 0;
    logic [W-1:0] pay [0:15];

    // Write monitor: every mem_we cycle must match the oldest expected write,
    // including the negedge at which it was predicted to appear.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (bus.mem_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr=%0h data=%08h expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.mem_addr !== mon_e.a || bus.mem_wdata !== mon_e.d || neg_cnt != mon_e.t) begin
                        failures++;
                        $display("FAIL write: got addr=%0h data=%08h cyc=%0d expected addr=%0h data=%08h cyc=%0d",
                                 bus.mem_addr, bus.mem_wdata, neg_cnt, mon_e.a, mon_e.d, mon_e.t);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string nm, input bit d, input bit e, input int wc);
        @(negedge clk);
        chk({nm, "_done"},  64'(bus.done), 64'(d));
        chk({nm, "_error"}, 64'(bus.error), 64'(e));
        chk({nm, "_hold"},  64'(bus.cpu_hold), 64'(e));
        chk({nm, "_busy"},  64'(bus.busy), 64'd0);
        chk({nm, "_wc"},    64'(bus.word_count), 64'(wc));
    endtask

    task automatic check_zero(input string nm);
        @(negedge clk);
        chk({nm, "_outs"}, {57'(bus.word_count), bus.mem_we, bus.cpu_hold, bus.busy,
                            bus.done, bus.error, 1'b0, 1'b0}, 64'd0);
        chk({nm, "_bus"}, {20'(bus.mem_addr), bus.mem_wdata}, 64'd0);
    endtask

    task automatic pulse_start(input bit with_bit);
        bus.start     = 1'b1;
        bus.bit_valid = with_bit;
        bus.bit_data  = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    // Sends the low nbits of w LSB-first; t_next is the negedge index right
    // after the strobe carrying the final bit.
    task automatic send_bits(input logic [W-1:0] w, input int nbits, output int t_next);
        for (int i = 0; i < nbits; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) tick();
            bus.bit_valid = 1'b1;
            bus.bit_data  = w[i];
            bus.start     = poke_start && ($urandom_range(7, 0) == 0);
            tick();
            bus.bit_valid = 1'b0;
            bus.start     = 1'b0;
        end
        t_next = neg_cnt + 1;
    endtask

    task automatic push_write(input int a, input logic [W-1:0] d, input int t);
        wr_t e;
        e.a = AW'(a);
        e.d = d;
        e.t = t;
        sb.push_back(e);
    endtask

    // Reference behaviour of one load: header n, payload pay[0..n-1],
    // optional trailer (good -> XOR of the payload, otherwise `trailer`).
    task automatic run_load(input string nm, input logic [W-1:0] n,
                            input logic [W-1:0] trailer, input bit good);
        logic [W-1:0] x;
        int t;
        x = '0;
        pulse_start(1'($urandom_range(1, 0)));
        send_bits(n, W, t);
        if (n == 0) begin
            check_status({nm, "_n0"}, 1'b1, 1'b0, 0);
        end else if (n > MAX) begin
            check_status({nm, "_big"}, 1'b0, 1'b1, 0);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                send_bits(pay[i], W, t);
                push_write(i, pay[i], t);
                x = x ^ pay[i];
            end
`ifdef LOAD_CHECKSUM_EN
            begin
                logic [W-1:0] tr;
                tr = good ? x : trailer;
                send_bits(tr, W, t);
                check_status({nm, "_csum"}, tr == x, tr != x, int'(n));
            end
`else
            check_status({nm, "_load"}, 1'b1, 1'b0, int'(n));
`endif
        end
    endtask

    initial begin
        int t;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_data  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_zero("reset");

        // Three-word load with varied bit patterns.
        gap_max = 2;
        pay[0] = 32'hDEADBEEF; pay[1] = 32'h00000001; pay[2] = 32'h80000000;
        run_load("t1", 32'd3, 32'h0, 1'b1);

        // Empty payload, then oversize header, then recovery.
        run_load("t2", 32'd0, 32'h0, 1'b1);
        run_load("t3", 32'd4097, 32'h0, 1'b1);
        pay[0] = 32'h12345678;
        run_load("t3b", 32'd1, 32'h0, 1'b1);

        // Reset in the middle of the third word: no further writes.
        pay[0] = 32'h0BADF00D; pay[1] = 32'h13579BDF; pay[2] = 32'h2468ACE0;
        pulse_start(1'b0);
        send_bits(32'd3, W, t);
        send_bits(pay[0], W, t); push_write(0, pay[0], t);
        send_bits(pay[1], W, t); push_write(1, pay[1], t);
        send_bits(pay[2], 10, t);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("t4_reset");
        repeat (40) tick();
        pay[0] = 32'hA5A5A5A5;
        run_load("t4b", 32'd1, 32'h0, 1'b1);

        // Back-to-back strobes with start pulses sprinkled through the load.
        gap_max = 0; poke_start = 1'b1;
        pay[0] = 32'hFFFFFFFF; pay[1] = 32'h0F0F0F0F;
        run_load("t5", 32'd2, 32'h0, 1'b1);
        poke_start = 1'b0;

`ifdef LOAD_CHECKSUM_EN
        pay[0] = 32'h1; pay[1] = 32'h2;
        run_load("t6_good", 32'd2, 32'h3, 1'b0);
        run_load("t6_bad", 32'd2, 32'h4, 1'b0);
`endif

        // Randomised loads; stray strobes after each must leave status alone.
        for (int it = 0; it < 14; it++) begin
            int kind, n_i, wc;
            logic [W-1:0] n;
            bit d, e, good;
            kind    = int'($urandom_range(9, 0));
            gap_max = int'($urandom_range(2, 0));
            poke_start = 1'($urandom_range(1, 0));
            good    = 1'($urandom_range(1, 0));
            if (kind == 0)      n = '0;
            else if (kind == 1) n = (it[0]) ? (32'(MAX) + 32'd1 + 32'($urandom_range(1000, 0)))
                                            : (32'($urandom) | 32'h80000000);
            else                n = 32'($urandom_range(5, 1));
            for (int i = 0; i < 16; i++) pay[i] = 32'($urandom);
            run_load("rnd", n, 32'($urandom), good);
            poke_start = 1'b0;
            d  = bus.done;
            e  = bus.error;
            n_i = (n > MAX) ? 0 : int'(n);
            wc = n_i;
            send_bits(32'($urandom), 5, t);
            check_status("rnd_stray", d, e, wc);
        end

        repeat (4) tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
